serial_byte_rx: RTL
===================

# serial_byte_rx

Asynchronous-serial byte receiver that consumes the single-bit line delivered by the two-register delay/synchronizer stage (its `c` output drives `din` here). It detects start bits, samples each bit at mid-bit using a clock-cycle counter, assembles LSB-first data bytes and presents them on a valid/ready output with framing-error and overrun reporting. It is the first stage in the design that does real protocol work on the synchronized line.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥4, even.
- `DATA_BITS`, 8: data bits per frame; legal range 5–8.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `din`  in  1  serial line, already synchronized upstream, idle high.
- `byte_out`  out  DATA_BITS  received data, LSB = first data bit.
- `byte_valid`  out  1  `byte_out` holds an unconsumed byte.
- `byte_ready`  in  1  consumer accepts the byte when high with `byte_valid`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- Reset values: state IDLE, bit counter 0, cycle counter 0, `byte_out`=0, `byte_valid`=0, `frame_err`=0, `overrun`=0.
- IDLE: on the first cycle with `din`=0, clear the cycle counter and go to START.
- START: at half-bit (`CLKS_PER_BIT/2` cycles after entry), sample `din`. If it is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE with no output.
- DATA: every `CLKS_PER_BIT` cycles, sample `din` into a shift register, LSB first. After `DATA_BITS` samples, go to STOP.
- STOP: `CLKS_PER_BIT` cycles after the last data sample, sample `din`.
  - If 1: commit the byte and go to IDLE.
  - If 0: pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: wait for `din`=1, then go to IDLE. No start bit is detected while `din` stays low.
- Commit rules:
  - If `byte_valid`=0, load `byte_out` and set `byte_valid`.
  - If `byte_valid`=1 and `byte_ready`=1 in the same cycle, load the new byte and keep `byte_valid`=1 with no overrun.
  - If `byte_valid`=1 and `byte_ready`=0, keep the old byte and pulse `overrun`.
- Handshake: `byte_valid` falls the cycle after `byte_valid & byte_ready` unless a commit happens in that cycle. `byte_out` is stable while `byte_valid`=1.
- Arithmetic: the cycle counter is `$clog2(CLKS_PER_BIT)` bits and the bit counter is `$clog2(DATA_BITS+1)` bits. The cycle counter restarts at each sample point; it never free-runs across a wrap.
- A reset during any state aborts the frame immediately. The partial byte is lost and all outputs return to their reset values.

## Timing
- Let H = `CLKS_PER_BIT/2` and P = `CLKS_PER_BIT`.
- Take cycle 0 as the cycle in which IDLE first sees `din`=0.
  - Start bit is checked at cycle H.
  - Data bit k is sampled at cycle H+(k+1)·P.
  - Stop bit is sampled at cycle H+(DATA_BITS+1)·P.
- `byte_valid`, `frame_err` and `overrun` are registered: they rise one cycle after the stop sample. With the defaults that is cycle 153.
- IDLE is re-entered the cycle after the stop sample, so the next start bit can be detected from that cycle onward.
- There is no throughput limit beyond line rate. One byte of buffering is provided.

## Structure
- Package `serial_rx_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - the default `CLKS_PER_BIT`/`DATA_BITS` constants;
  - counter-width helper functions.
- One sub-module, `bit_timer`, contains the cycle counter. It has a restart input and emits single-cycle `half_tick` and `full_tick` strobes. The FSM, shift register and output holding register stay in `serial_byte_rx`.

## Test plan
- Frame 0xA5 with default parameters and `byte_ready`=1 → `byte_valid` is high only at cycle 153 with `byte_out`=0xA5; `frame_err` and `overrun` stay 0.
- `din` low for 4 cycles then high → no `byte_valid`, FSM back in IDLE by cycle 8, then a following 0x3C frame is received correctly.
- Frame 0x81 with stop bit 0 and `din` held low 40 more cycles → `frame_err` pulses once at cycle 153 with no `byte_valid`. No start is detected until `din` returns high, after which 0x55 is received.
- Frames 0x3C then 0xC3 back-to-back with `byte_ready`=0 → `byte_out` stays 0x3C and `overrun` pulses once at the second commit. Then `byte_ready`=1 → `byte_valid` falls the next cycle.
- `byte_ready` asserted in exactly the second frame's commit cycle → `byte_out`=0xC3, `byte_valid` stays 1 and there is no `overrun`.
- `rst` asserted during data bit 3 of a frame → all outputs 0 asynchronously. After release, frame 0x5A is received correctly.

Source files
------------

// File: rtl/serial_byte_rx_pkg.sv
// serial_byte_rx_pkg: shared state encoding, default parameters and counter-width helpers.
package serial_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS_DEF = 8;
    function automatic int cyc_w(input int clks);
        return $clog2(clks);
    endfunction
    function automatic int bit_w(input int bits);
        return $clog2(bits + 1);
    endfunction
endpackage

// File: rtl/serial_byte_rx_if.sv
// serial_byte_rx_if: serial line input plus byte valid/ready output bundle.
interface serial_byte_rx_if import serial_rx_pkg::*; #(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 din;
    logic                 byte_ready;
    logic [DATA_BITS-1:0] byte_out;
    logic                 byte_valid;
    logic                 frame_err;
    logic                 overrun;
    modport master (output din, byte_ready, input byte_out, byte_valid, frame_err, overrun);
    modport slave (input din, byte_ready, output byte_out, byte_valid, frame_err, overrun);
endinterface

// File: rtl/serial_byte_rx_bit_timer.sv
// bit_timer: cycle counter that strobes at half-bit and full-bit after each restart.
module bit_timer import serial_rx_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic half_tick_o,
    output logic full_tick_o
);
    localparam int CW = cyc_w(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    // The count is 0 on the cycle after restart, so tick at N-1 lands N cycles after the restart cycle.
    always_comb cnt_d = restart_i ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign half_tick_o = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
    assign full_tick_o = cnt_q == CW'(CLKS_PER_BIT - 1);
endmodule

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: start-bit detect, mid-bit sampling, LSB-first assembly, one-byte output buffer.
module serial_byte_rx import serial_rx_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic clk,
    input  logic rst,
    serial_byte_rx_if.slave rx
);
    localparam int BW = bit_w(DATA_BITS);
    state_t               state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, byte_q, byte_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 half_tick, full_tick, restart, commit;
    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk(clk),
        .rst(rst),
        .restart_i(restart),
        .half_tick_o(half_tick),
        .full_tick_o(full_tick)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        restart   = 1'b0;
        commit    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                restart = 1'b1;
                if (!rx.din) state_d = START;
            end
            START: if (half_tick) begin
                restart   = 1'b1;
                bit_cnt_d = '0;
                state_d   = rx.din ? IDLE : DATA;
            end
            DATA: if (full_tick) begin
                restart   = 1'b1;
                shift_d   = {rx.din, shift_q[DATA_BITS-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
            end
            STOP: if (full_tick) begin
                restart = 1'b1;
                commit  = rx.din;
                ferr_d  = !rx.din;
                state_d = rx.din ? IDLE : BREAK;
            end
            BREAK: begin
                restart = 1'b1;
                if (rx.din) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A consumer taking the old byte in the commit cycle frees the buffer for the new one.
        valid_d = commit | (valid_q & ~rx.byte_ready);
        byte_d  = (commit & (~valid_q | rx.byte_ready)) ? shift_q : byte_q;
        ovr_d   = commit & valid_q & ~rx.byte_ready;
    end
    assign rx.byte_out   = byte_q;
    assign rx.byte_valid = valid_q;
    assign rx.frame_err  = ferr_q;
    assign rx.overrun    = ovr_q;
endmodule
